// File: rtl/sort_window_filter.sv
// Sorted window of up to DEPTH samples (accumulate or sliding) with rank/median, MIN, MAX and occupancy.
// Array updates on the VALID edge, outputs register one edge later; accepts VALID every cycle, no stall.
module sort_window_filter #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 16,
  parameter bit SIGNED     = 1'b0,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RSTb,
  input  logic                  CLR,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic                  VALID,
  input  logic                  MODE,
  input  logic                  USE_MEDIAN,
  input  logic [CW-1:0]         RANK_SEL,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic [DATA_WIDTH-1:0] MIN,
  output logic [DATA_WIDTH-1:0] MAX,
  output logic                  DO_VALID,
  output logic [CW-1:0]         N_CELLS,
  output logic                  FULL,
  output logic                  DROPPED
);

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [CW-1:0]         cnt_t;

  data_t val_q [DEPTH];
  data_t val_d [DEPTH];
  cnt_t  age_q [DEPTH];
  cnt_t  age_d [DEPTH];
  cnt_t  cnt_q, cnt_d;
  logic  stb_q, drop_q;

  data_t r_val [DEPTH];
  cnt_t  r_age [DEPTH];
  cnt_t  r_cnt, pos, ev_idx;
  logic  full, take, accept, evict, found;

  data_t dout_q, min_q, max_q;
  cnt_t  n_q;
  logic  dov_q, full_q, dropped_q;
  data_t dout_sel, max_sel;
  cnt_t  last_idx, sel_idx;

  function automatic logic le(input data_t a, input data_t b);
    if (SIGNED) return $signed(a) <= $signed(b);
    else        return a <= b;
  endfunction

  function automatic cnt_t age_inc(input cnt_t a);
    return (a == CW'(DEPTH - 1)) ? a : a + CW'(1);
  endfunction

  always_comb begin
    full   = (cnt_q == CW'(DEPTH));
    take   = VALID && !CLR;
    accept = take && !(full && !MODE);
    evict  = accept && full;

    ev_idx = '0;
    found  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && CW'(i) < cnt_q && age_q[i] == CW'(DEPTH - 1)) begin
        ev_idx = CW'(i);
        found  = 1'b1;
      end
    end

    // Retained array: evicted cell removed and the cells above it compacted down.
    for (int i = 0; i < DEPTH; i++) begin
      if (evict && CW'(i) >= ev_idx) begin
        r_val[i] = val_q[(i < DEPTH - 1) ? i + 1 : i];
        r_age[i] = age_q[(i < DEPTH - 1) ? i + 1 : i];
      end else begin
        r_val[i] = val_q[i];
        r_age[i] = age_q[i];
      end
    end
    r_cnt = cnt_q - CW'(evict);

    pos = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < r_cnt && le(r_val[i], DIN)) pos = pos + CW'(1);
    end

    val_d = val_q;
    age_d = age_q;
    cnt_d = cnt_q;
    if (CLR) begin
      for (int i = 0; i < DEPTH; i++) begin
        val_d[i] = '0;
        age_d[i] = '0;
      end
      cnt_d = '0;
    end else if (accept) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) < pos) begin
          val_d[i] = r_val[i];
          age_d[i] = age_inc(r_age[i]);
        end else if (CW'(i) == pos) begin
          val_d[i] = DIN;
          age_d[i] = '0;
        end else begin
          val_d[i] = r_val[(i > 0) ? i - 1 : 0];
          age_d[i] = age_inc(r_age[(i > 0) ? i - 1 : 0]);
        end
      end
      cnt_d = r_cnt + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      for (int i = 0; i < DEPTH; i++) begin
        val_q[i] <= '0;
        age_q[i] <= '0;
      end
      cnt_q  <= '0;
      stb_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      val_q  <= val_d;
      age_q  <= age_d;
      cnt_q  <= cnt_d;
      stb_q  <= take;
      drop_q <= take && full && !MODE;
    end
  end

  always_comb begin
    last_idx = cnt_q - CW'(1);
    if (USE_MEDIAN)          sel_idx = last_idx >> 1;
    else if (RANK_SEL < cnt_q) sel_idx = RANK_SEL;
    else                     sel_idx = last_idx;
    dout_sel = '0;
    max_sel  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) == sel_idx)  dout_sel = val_q[i];
      if (CW'(i) == last_idx) max_sel  = val_q[i];
    end
  end

  // Output stage samples the array one edge after it was updated.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      dout_q    <= '0;
      min_q     <= '0;
      max_q     <= '0;
      n_q       <= '0;
      full_q    <= 1'b0;
      dov_q     <= 1'b0;
      dropped_q <= 1'b0;
    end else if (CLR) begin
      dout_q    <= '0;
      min_q     <= '0;
      max_q     <= '0;
      n_q       <= '0;
      full_q    <= 1'b0;
      dov_q     <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      dov_q     <= stb_q;
      dropped_q <= drop_q;
      if (stb_q) begin
        dout_q <= dout_sel;
        min_q  <= val_q[0];
        max_q  <= max_sel;
        n_q    <= cnt_q;
        full_q <= full;
      end
    end
  end

  assign DOUT     = dout_q;
  assign MIN      = min_q;
  assign MAX      = max_q;
  assign N_CELLS  = n_q;
  assign FULL     = full_q;
  assign DO_VALID = dov_q;
  assign DROPPED  = dropped_q;

endmodule

// File: tb/tb_sort_window_filter.sv
// Directed bench for sort_window_filter: an unsigned and a signed DEPTH=4 instance share one stimulus stream.
module tb_sort_window_filter;
  localparam int DW  = 8;
  localparam int DEP = 4;
  localparam int CW  = $clog2(DEP + 1);

  logic          CLK = 1'b0;
  logic          RSTb = 1'b1;
  logic          CLR = 1'b0;
  logic          VALID = 1'b0;
  logic          MODE = 1'b0;
  logic          USE_MEDIAN = 1'b1;
  logic [DW-1:0] DIN = '0;
  logic [CW-1:0] RANK_SEL = '0;

  logic [DW-1:0] dout_u, min_u, max_u, dout_s, min_s, max_s;
  logic [CW-1:0] n_u, n_s;
  logic          dov_u, full_u, drop_u, dov_s, full_s, drop_s;

  int vectors = 0;
  int errors  = 0;

  always #5 CLK = ~CLK;

  sort_window_filter #(.DATA_WIDTH(DW), .DEPTH(DEP), .SIGNED(1'b0)) u_u (
    .CLK(CLK), .RSTb(RSTb), .CLR(CLR), .DIN(DIN), .VALID(VALID), .MODE(MODE),
    .USE_MEDIAN(USE_MEDIAN), .RANK_SEL(RANK_SEL), .DOUT(dout_u), .MIN(min_u),
    .MAX(max_u), .DO_VALID(dov_u), .N_CELLS(n_u), .FULL(full_u), .DROPPED(drop_u));

  sort_window_filter #(.DATA_WIDTH(DW), .DEPTH(DEP), .SIGNED(1'b1)) u_s (
    .CLK(CLK), .RSTb(RSTb), .CLR(CLR), .DIN(DIN), .VALID(VALID), .MODE(MODE),
    .USE_MEDIAN(USE_MEDIAN), .RANK_SEL(RANK_SEL), .DOUT(dout_s), .MIN(min_s),
    .MAX(max_s), .DO_VALID(dov_s), .N_CELLS(n_s), .FULL(full_s), .DROPPED(drop_s));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_u(input string tag, input int e_dout, input int e_min,
                       input int e_max, input int e_n, input int e_full);
    chk({tag, ".u.dout"}, 32'(dout_u), e_dout);
    chk({tag, ".u.min"},  32'(min_u),  e_min);
    chk({tag, ".u.max"},  32'(max_u),  e_max);
    chk({tag, ".u.n"},    32'(n_u),    e_n);
    chk({tag, ".u.full"}, 32'(full_u), e_full);
  endtask

  task automatic chk_s(input string tag, input int e_dout, input int e_min,
                       input int e_max, input int e_n, input int e_full);
    chk({tag, ".s.dout"}, 32'(dout_s), e_dout);
    chk({tag, ".s.min"},  32'(min_s),  e_min);
    chk({tag, ".s.max"},  32'(max_s),  e_max);
    chk({tag, ".s.n"},    32'(n_s),    e_n);
    chk({tag, ".s.full"}, 32'(full_s), e_full);
  endtask

  task automatic chk_stb(input string tag, input int e_dov, input int e_drop);
    chk({tag, ".u.do_valid"}, 32'(dov_u),  e_dov);
    chk({tag, ".u.dropped"},  32'(drop_u), e_drop);
  endtask

  task automatic chk_zero(input string tag);
    chk_u(tag, 0, 0, 0, 0, 0);
    chk_s(tag, 0, 0, 0, 0, 0);
    chk_stb(tag, 0, 0);
    chk({tag, ".s.do_valid"}, 32'(dov_s),  0);
    chk({tag, ".s.dropped"},  32'(drop_s), 0);
  endtask

  // One sample, then wait until its registered outputs are visible.
  task automatic send(input logic [DW-1:0] d);
    @(negedge CLK);
    DIN = d;
    VALID = 1'b1;
    @(negedge CLK);
    VALID = 1'b0;
    @(negedge CLK);
  endtask

  task automatic clr_pulse();
    @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
  endtask

  initial begin
    #2 RSTb = 1'b0;
    #1 chk_zero("reset");
    @(negedge CLK);
    RSTb = 1'b1;

    // Sliding window fill
    MODE = 1'b1;
    USE_MEDIAN = 1'b1;
    send(8'd5); chk_u("w5", 5, 5, 5, 1, 0); chk_stb("w5", 1, 0);
    send(8'd1); chk_u("w1", 1, 1, 5, 2, 0);
    send(8'd9); chk_u("w9", 5, 1, 9, 3, 0);
    send(8'd3); chk_u("w3", 3, 1, 9, 4, 1);
    @(negedge CLK); chk_stb("w3.hold", 0, 0); chk_u("w3.hold", 3, 1, 9, 4, 1);

    // Back-to-back evictions: 5, 1, 9 leave in turn
    @(negedge CLK); DIN = 8'd7; VALID = 1'b1;
    @(negedge CLK); DIN = 8'd2;
    @(negedge CLK); DIN = 8'd8; chk_u("s7", 3, 1, 9, 4, 1); chk_stb("s7", 1, 0);
    @(negedge CLK); VALID = 1'b0; chk_u("s2", 3, 2, 9, 4, 1); chk_stb("s2", 1, 0);
    @(negedge CLK); chk_u("s8", 3, 2, 8, 4, 1); chk_stb("s8", 1, 0);
    @(negedge CLK); chk_stb("s8.end", 0, 0);

    // CLR wins over a simultaneous sample
    @(negedge CLK); CLR = 1'b1; VALID = 1'b1; DIN = 8'h55;
    @(negedge CLK); CLR = 1'b0; VALID = 1'b0; chk_u("clr", 0, 0, 0, 0, 0); chk_stb("clr", 0, 0);
    @(negedge CLK); chk_stb("clr.next", 0, 0); chk("clr.next.u.n", 32'(n_u), 0);

    // Accumulate with duplicates, then drop when full
    MODE = 1'b0;
    send(8'd4); send(8'd4); send(8'd4); chk_u("a4", 4, 4, 4, 3, 0);
    send(8'd2); chk_u("a2", 4, 2, 4, 4, 1); chk_stb("a2", 1, 0);
    send(8'd6); chk_u("a6", 4, 2, 4, 4, 1); chk_stb("a6", 1, 1);
    @(negedge CLK); chk_stb("a6.after", 0, 0);

    // Switch to sliding while full: oldest 4 leaves, then the next-oldest 4
    MODE = 1'b1;
    send(8'd3); chk_u("m3", 3, 2, 4, 4, 1); chk_stb("m3", 1, 0);
    send(8'd1); chk_u("m1", 2, 1, 4, 4, 1);

    // Rank selection with clamping
    clr_pulse();
    MODE = 1'b0;
    USE_MEDIAN = 1'b0;
    RANK_SEL = 3'd7;
    send(8'd1); chk_u("r7a", 1, 1, 1, 1, 0);
    send(8'd2); chk_u("r7b", 2, 1, 2, 2, 0);
    send(8'd3); chk_u("r7c", 3, 1, 3, 3, 0);
    RANK_SEL = 3'd1;
    send(8'd0); chk_u("r1", 1, 0, 3, 4, 1);

    // Signed versus unsigned ordering of the same samples
    clr_pulse();
    USE_MEDIAN = 1'b1;
    send(8'h05); send(8'hFB); send(8'h00);
    chk_s("sg", 8'h00, 8'hFB, 8'h05, 3, 0);
    chk_u("ug", 8'h05, 8'h00, 8'hFB, 3, 0);

    // Asynchronous reset in the middle of a burst
    @(negedge CLK); DIN = 8'h20; VALID = 1'b1;
    @(negedge CLK); DIN = 8'h30;
    @(posedge CLK); #2 RSTb = 1'b0; VALID = 1'b0;
    #1 chk_zero("rst_mid");
    @(negedge CLK); RSTb = 1'b1;
    @(negedge CLK); chk_stb("rst_rel", 0, 0);
    send(8'h10);
    chk_u("p10", 8'h10, 8'h10, 8'h10, 1, 0);
    chk_s("p10", 8'h10, 8'h10, 8'h10, 1, 0);
    chk_stb("p10", 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
